// File: rtl/vliw_writeback_q.sv
// Writeback stage for the VLIW core, sitting between execute and the register file.
// It registers one bundle of per-pipe results and drives the register-file write ports.
// Within a bundle, the highest-index pipe wins a same-destination write collision.
// Read results are buffered in a small FIFO with a valid/ready drain port.
module vliw_writeback_q #(
  parameter int NPIPE     = 3,
  parameter int DW        = 64,
  parameter int AW        = 4,
  parameter int RDQ_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  stall,
  input  logic [NPIPE*AW-1:0]   e2w_dest,
  input  logic [NPIPE*DW-1:0]   e2w_data,
  input  logic [NPIPE-1:0]      e2w_wr,
  input  logic [NPIPE-1:0]      e2w_read,
  output logic                  w2e_stall,
  output logic [NPIPE-1:0]      w2r_wr,
  output logic [NPIPE*AW-1:0]   w2re_dest,
  output logic [NPIPE*DW-1:0]   w2re_data,
  output logic                  wr_conflict,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [NPIPE*DW-1:0]   rd_data,
  output logic [NPIPE-1:0]      rd_mask
);

  localparam int PW = (RDQ_DEPTH > 1) ? $clog2(RDQ_DEPTH) : 1;
  localparam int CW = $clog2(RDQ_DEPTH) + 1;

  // Write-port state
  logic [NPIPE-1:0]    wr_reg;
  logic [NPIPE*AW-1:0] dest_reg;
  logic [NPIPE*DW-1:0] data_reg;
  logic                conflict_reg;

  // Read-queue state; storage is a plain register array read at the head pointer
  logic [NPIPE*DW-1:0] mem_data [RDQ_DEPTH];
  logic [NPIPE-1:0]    mem_mask [RDQ_DEPTH];
  logic [PW-1:0]       wr_ptr_reg;
  logic [PW-1:0]       rd_ptr_reg;
  logic [CW-1:0]       count_reg;

  logic                any_rd;
  logic                rdq_full;
  logic                accept;
  logic                push;
  logic                pop;
  logic [NPIPE-1:0]    suppress;
  logic [NPIPE-1:0]    wr_next;
  logic [NPIPE*DW-1:0] push_data;

  assign any_rd   = |e2w_read;
  // Full is judged on the registered count, ignoring a same-cycle pop, so the
  // stall path never depends on rd_ready.
  assign rdq_full = (count_reg == CW'(RDQ_DEPTH));
  assign w2e_stall = ~flush & (stall | (rdq_full & any_rd));
  assign accept    = ~flush & ~w2e_stall;
  assign push      = accept & any_rd;
  assign pop       = rd_valid & rd_ready;

  // Per-pipe collision detect and read-lane masking
  for (genvar gi = 0; gi < NPIPE; gi++) begin : g_pipe
    logic later_hit;

    // A pipe loses its write if any higher-index pipe writes the same register
    always_comb begin
      later_hit = 1'b0;
      for (int j = gi + 1; j < NPIPE; j++) begin
        if (e2w_wr[j] && (e2w_dest[j*AW +: AW] == e2w_dest[gi*AW +: AW])) begin
          later_hit = 1'b1;
        end
      end
    end

    assign suppress[gi] = e2w_wr[gi] & later_hit;
    assign wr_next[gi]  = e2w_wr[gi] & ~later_hit;
    assign push_data[gi*DW +: DW] = e2w_read[gi] ? e2w_data[gi*DW +: DW] : '0;
  end

  // Write-port register: flush clears, stall inserts a bubble and holds dest/data
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_reg       <= '0;
      dest_reg     <= '0;
      data_reg     <= '0;
      conflict_reg <= 1'b0;
    end else if (flush) begin
      wr_reg       <= '0;
      dest_reg     <= '0;
      data_reg     <= '0;
      conflict_reg <= 1'b0;
    end else if (accept) begin
      wr_reg       <= wr_next;
      dest_reg     <= e2w_dest;
      data_reg     <= e2w_data;
      conflict_reg <= |suppress;
    end else begin
      wr_reg       <= '0;
      conflict_reg <= 1'b0;
    end
  end

  // Queue storage write; contents are qualified by count, so no reset is needed
  always_ff @(posedge clock) begin
    if (push) begin
      mem_data[wr_ptr_reg] <= push_data;
      mem_mask[wr_ptr_reg] <= e2w_read;
    end
  end

  // Queue pointers and occupancy; power-of-two depth lets pointers wrap naturally
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      if (push && !pop)      count_reg <= count_reg + CW'(1);
      else if (pop && !push) count_reg <= count_reg - CW'(1);
    end
  end

  assign w2r_wr      = wr_reg;
  assign w2re_dest   = dest_reg;
  assign w2re_data   = data_reg;
  assign wr_conflict = conflict_reg;
  assign rd_valid    = (count_reg != '0);
  assign rd_data     = rd_valid ? mem_data[rd_ptr_reg] : '0;
  assign rd_mask     = rd_valid ? mem_mask[rd_ptr_reg] : '0;

endmodule

// File: tb/tb_vliw_writeback_q.sv
// Directed bench for vliw_writeback_q: write path, collisions, read queue,
// back-pressure, flush/stall and mid-operation reset.
module tb_vliw_writeback_q;
  localparam int NPIPE = 3;
  localparam int DW    = 64;
  localparam int AW    = 4;

  logic                clock = 1'b0;
  logic                reset;
  logic                flush;
  logic                stall;
  logic [NPIPE*AW-1:0] e2w_dest;
  logic [NPIPE*DW-1:0] e2w_data;
  logic [NPIPE-1:0]    e2w_wr;
  logic [NPIPE-1:0]    e2w_read;
  logic                w2e_stall;
  logic [NPIPE-1:0]    w2r_wr;
  logic [NPIPE*AW-1:0] w2re_dest;
  logic [NPIPE*DW-1:0] w2re_data;
  logic                wr_conflict;
  logic                rd_valid;
  logic                rd_ready;
  logic [NPIPE*DW-1:0] rd_data;
  logic [NPIPE-1:0]    rd_mask;

  int total = 0;
  int bad   = 0;

  vliw_writeback_q #(.NPIPE(NPIPE), .DW(DW), .AW(AW), .RDQ_DEPTH(4)) dut (
    .clock(clock), .reset(reset), .flush(flush), .stall(stall),
    .e2w_dest(e2w_dest), .e2w_data(e2w_data), .e2w_wr(e2w_wr), .e2w_read(e2w_read),
    .w2e_stall(w2e_stall), .w2r_wr(w2r_wr), .w2re_dest(w2re_dest), .w2re_data(w2re_data),
    .wr_conflict(wr_conflict), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_mask(rd_mask)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic bundle(input logic [3:0] d2, input logic [3:0] d1, input logic [3:0] d0,
                        input logic [63:0] x2, input logic [63:0] x1, input logic [63:0] x0,
                        input logic [2:0] wr, input logic [2:0] rd);
    e2w_dest = {d2, d1, d0};
    e2w_data = {x2, x1, x0};
    e2w_wr   = wr;
    e2w_read = rd;
    #1;
  endtask

  task automatic idle();
    bundle(4'd0, 4'd0, 4'd0, 64'd0, 64'd0, 64'd0, 3'b000, 3'b000);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; stall = 1'b0; rd_ready = 1'b0;
    idle();
    tick(); tick();
    reset = 1'b0;
    $display("reset check");
    chk("rst_wr", w2r_wr, 3'b000);
    chk("rst_dest", w2re_dest, 12'h000);
    chk("rst_data", w2re_data, 192'd0);
    chk("rst_conf", wr_conflict, 1'b0);
    chk("rst_rdv", rd_valid, 1'b0);
    chk("rst_rdd", rd_data, 192'd0);
    chk("rst_rdm", rd_mask, 3'b000);

    // Basic write bundle
    bundle(4'd3, 4'd2, 4'd1, 64'hC, 64'hB, 64'hA, 3'b111, 3'b000);
    chk("basic_stall", w2e_stall, 1'b0);
    tick();
    $display("basic bundle");
    chk("basic_wr", w2r_wr, 3'b111);
    chk("basic_dest", w2re_dest, 12'h321);
    chk("basic_data", w2re_data, {64'hC, 64'hB, 64'hA});
    chk("basic_conf", wr_conflict, 1'b0);
    chk("basic_rdv", rd_valid, 1'b0);

    // Collisions
    bundle(4'd5, 4'd7, 4'd5, 64'h3, 64'h2, 64'h1, 3'b111, 3'b000);
    tick();
    $display("collision 5,7,5");
    chk("col1_wr", w2r_wr, 3'b110);
    chk("col1_conf", wr_conflict, 1'b1);
    idle();
    tick();
    chk("col1_pulse", wr_conflict, 1'b0);
    bundle(4'd4, 4'd4, 4'd4, 64'h3, 64'h2, 64'h1, 3'b111, 3'b000);
    tick();
    $display("collision 4,4,4");
    chk("col2_wr", w2r_wr, 3'b100);
    chk("col2_conf", wr_conflict, 1'b1);

    // Fill the read queue with rd_ready low; other lanes carry junk to check masking
    for (int k = 0; k < 4; k++) begin
      bundle(4'd0, 4'd0, 4'd9, 64'hEE, 64'h10 + 64'(k), 64'hFF, 3'b001, 3'b010);
      chk("fill_stall", w2e_stall, 1'b0);
      tick();
      $display("fill push %0d", k);
    end
    chk("fill_rdv", rd_valid, 1'b1);
    chk("fill_head", rd_data, {64'h0, 64'h10, 64'h0});
    chk("fill_mask", rd_mask, 3'b010);
    chk("fill_wr", w2r_wr, 3'b001);

    // Fifth read bundle is back-pressured
    bundle(4'd0, 4'd0, 4'd8, 64'hEE, 64'h14, 64'h77, 3'b001, 3'b010);
    chk("full_stall", w2e_stall, 1'b1);
    tick();
    $display("full stall");
    chk("full_wr", w2r_wr, 3'b000);
    chk("full_hold", w2re_data, {64'hEE, 64'h13, 64'hFF});
    chk("full_stall2", w2e_stall, 1'b1);

    // Drain; the stalled bundle gets in once space appears
    rd_ready = 1'b1; #1;
    chk("pop0", rd_data, {64'h0, 64'h10, 64'h0});
    tick();
    $display("pop 0x10");
    chk("pop1", rd_data, {64'h0, 64'h11, 64'h0});
    chk("retry_stall", w2e_stall, 1'b0);
    tick();
    $display("pop 0x11, stalled bundle accepted");
    chk("retry_wr", w2r_wr, 3'b001);
    chk("retry_dest", w2re_dest, 12'h008);
    idle();
    chk("pop2", rd_data, {64'h0, 64'h12, 64'h0});
    tick();
    chk("pop3", rd_data, {64'h0, 64'h13, 64'h0});
    chk("pop3_mask", rd_mask, 3'b010);
    tick();
    chk("pop4", rd_data, {64'h0, 64'h14, 64'h0});
    tick();
    $display("queue drained");
    chk("drain_rdv", rd_valid, 1'b0);
    chk("drain_rdd", rd_data, 192'd0);
    chk("drain_rdm", rd_mask, 3'b000);

    // Simultaneous push and pop at occupancy 2
    rd_ready = 1'b0;
    bundle(4'd0, 4'd0, 4'd0, 64'h0, 64'h20, 64'h0, 3'b000, 3'b010);
    tick();
    bundle(4'd0, 4'd0, 4'd0, 64'h0, 64'h21, 64'h0, 3'b000, 3'b010);
    tick();
    bundle(4'd0, 4'd0, 4'd0, 64'h0, 64'h22, 64'h0, 3'b000, 3'b010);
    rd_ready = 1'b1; #1;
    chk("pp_head0", rd_data, {64'h0, 64'h20, 64'h0});
    tick();
    $display("push+pop at count 2");
    idle();
    chk("pp_head1", rd_data, {64'h0, 64'h21, 64'h0});
    tick();
    chk("pp_head2", rd_data, {64'h0, 64'h22, 64'h0});
    tick();
    chk("pp_empty", rd_valid, 1'b0);
    tick();
    $display("pop on empty");
    chk("pe_rdv", rd_valid, 1'b0);
    rd_ready = 1'b0;
    bundle(4'd0, 4'd0, 4'd0, 64'h0, 64'h30, 64'h0, 3'b000, 3'b010);
    tick();
    idle();
    chk("pe_head", rd_data, {64'h0, 64'h30, 64'h0});
    chk("pe_rdv2", rd_valid, 1'b1);

    // Flush with stall: dropped bundle, queue untouched
    flush = 1'b1; stall = 1'b1;
    bundle(4'd3, 4'd2, 4'd1, 64'h9, 64'h8, 64'h7, 3'b111, 3'b001);
    chk("flush_stall", w2e_stall, 1'b0);
    tick();
    $display("flush");
    flush = 1'b0; stall = 1'b0;
    idle();
    chk("flush_wr", w2r_wr, 3'b000);
    chk("flush_dest", w2re_dest, 12'h000);
    chk("flush_data", w2re_data, 192'd0);
    chk("flush_conf", wr_conflict, 1'b0);
    chk("flush_head", rd_data, {64'h0, 64'h30, 64'h0});
    rd_ready = 1'b1;
    tick();
    chk("flush_nopush", rd_valid, 1'b0);
    rd_ready = 1'b0;

    // Stall holds dest/data and bubbles the write enables
    bundle(4'd6, 4'd5, 4'd4, 64'h66, 64'h55, 64'h44, 3'b011, 3'b000);
    tick();
    stall = 1'b1;
    bundle(4'd1, 4'd1, 4'd1, 64'h1, 64'h1, 64'h1, 3'b111, 3'b000);
    chk("stall_out", w2e_stall, 1'b1);
    tick();
    $display("stall");
    chk("stall_wr", w2r_wr, 3'b000);
    chk("stall_data", w2re_data, {64'h66, 64'h55, 64'h44});
    chk("stall_dest", w2re_dest, 12'h654);
    stall = 1'b0;

    // Reset mid-operation with three queued entries
    for (int k = 0; k < 3; k++) begin
      bundle(4'd2, 4'd1, 4'd3, 64'h0, 64'h0, 64'h40 + 64'(k), 3'b011, 3'b001);
      tick();
    end
    chk("pre_rst_wr", w2r_wr, 3'b011);
    chk("pre_rst_rdv", rd_valid, 1'b1);
    reset = 1'b1;
    tick();
    $display("mid-op reset");
    reset = 1'b0;
    idle();
    chk("mr_wr", w2r_wr, 3'b000);
    chk("mr_dest", w2re_dest, 12'h000);
    chk("mr_data", w2re_data, 192'd0);
    chk("mr_conf", wr_conflict, 1'b0);
    chk("mr_rdv", rd_valid, 1'b0);
    chk("mr_rdd", rd_data, 192'd0);
    chk("mr_rdm", rd_mask, 3'b000);
    bundle(4'd0, 4'd0, 4'd0, 64'h0, 64'h0, 64'h55, 3'b000, 3'b001);
    tick();
    idle();
    chk("mr_new_rdv", rd_valid, 1'b1);
    chk("mr_new_rdd", rd_data, {64'h0, 64'h0, 64'h55});
    chk("mr_new_rdm", rd_mask, 3'b001);
    rd_ready = 1'b1;
    tick();
    $display("post-reset single entry");
    chk("mr_only", rd_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
